// File: rtl/cpu_mem_pkg.sv
// Shared memory-subsystem types and default widths.
// Used by the RAM arbiter and reused by ram/fetch/memory blocks.
//   arb_state_t : arbiter transaction phase (IDLE -> ACCESS -> RESP)
//   owner_t     : which pipeline stage owns the in-flight RAM transaction
package cpu_mem_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_MEM
    } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the pipeline (fetch + memory stage), the arbiter and the RAM.
// Ports (arbiter view, modport slave):
//   in : if_req, if_addr, if_flush, mem_req, mem_we, mem_addr, mem_wdata, ram_data_out
//   out: if_gnt, if_rvalid, if_rdata, mem_gnt, mem_rvalid, mem_rdata,
//        ram_address, ram_data_in, ram_write_enable
// modport master is the pipeline/RAM side of the same bundle.
interface mem_arbiter_if
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data_in;
    logic              ram_write_enable;
    logic [DATA_W-1:0] ram_data_out;

    modport slave (
        input  if_req, if_addr, if_flush, mem_req, mem_we, mem_addr, mem_wdata, ram_data_out,
        output if_gnt, if_rvalid, if_rdata, mem_gnt, mem_rvalid, mem_rdata,
               ram_address, ram_data_in, ram_write_enable
    );

    modport master (
        output if_req, if_addr, if_flush, mem_req, mem_we, mem_addr, mem_wdata, ram_data_out,
        input  if_gnt, if_rvalid, if_rdata, mem_gnt, mem_rvalid, mem_rdata,
               ram_address, ram_data_in, ram_write_enable
    );
endinterface

// File: rtl/mem_arb_pick.sv
// Winner select for the shared RAM: memory stage has fixed priority, but after
// MAX_STREAK back-to-back memory grants with fetch waiting, fetch is forced through.
// Ports:
//   clk, rst        clock / async active-low reset
//   idle            arbiter can accept a request this cycle
//   ifReq, memReq   raw requests
//   ifWin, memWin   combinational grants (at most one set)
module mem_arb_pick
    import cpu_mem_pkg::*;
#(
    parameter int MAX_STREAK = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic idle,
    input  logic ifReq,
    input  logic memReq,
    output logic ifWin,
    output logic memWin
);
    localparam int SW = $clog2(MAX_STREAK + 1);

    logic [SW-1:0] streak;
    logic          forceIf;

    assign forceIf = ifReq && (streak == SW'(MAX_STREAK));
    assign memWin  = idle && memReq && !forceIf;
    assign ifWin   = idle && ifReq && !memWin;

    // Streak only counts memory grants that actually made fetch wait.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            streak <= '0;
        end else if (idle) begin
            if (!ifReq || ifWin)
                streak <= '0;
            else if (memWin && streak != SW'(MAX_STREAK))
                streak <= streak + 1'b1;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-ported data RAM between fetch (reads) and the memory stage
// (loads/stores). One transaction in flight: IDLE (grant) -> ACCESS (RAM_LATENCY
// cycles) -> RESP (one-cycle rvalid to the owner). Fetch responses can be dropped
// by if_flush (taken branch) without disturbing the RAM access itself.
// Ports:
//   clk  clock, rising edge
//   rst  asynchronous reset, active low
//   bus  mem_arbiter_if.slave: fetch/memory handshakes and RAM signals
module mem_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int RAM_LATENCY = 1,
    parameter int MAX_STREAK  = 4
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    localparam int LW = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;

    arb_state_t        state, stateNext;
    owner_t            owner;
    logic              latWe;
    logic [ADDR_W-1:0] latAddr;
    logic [DATA_W-1:0] latWdata;
    logic [LW-1:0]     latCnt;
    logic              flushPend;
    logic [DATA_W-1:0] ifRdata, memRdata;
    logic              arbIdle, ifWin, memWin;

    // Gating with rst keeps the grants low while reset is held.
    assign arbIdle = (state == IDLE) && rst;

    mem_arb_pick #(.MAX_STREAK(MAX_STREAK)) uPick (
        .clk   (clk),
        .rst   (rst),
        .idle  (arbIdle),
        .ifReq (bus.if_req),
        .memReq(bus.mem_req),
        .ifWin (ifWin),
        .memWin(memWin)
    );

    assign bus.if_gnt    = ifWin;
    assign bus.mem_gnt   = memWin;
    assign bus.if_rdata  = ifRdata;
    assign bus.mem_rdata = memRdata;

    always_comb begin
        stateNext            = state;
        bus.ram_address      = '0;
        bus.ram_data_in      = '0;
        bus.ram_write_enable = 1'b0;
        bus.if_rvalid        = 1'b0;
        bus.mem_rvalid       = 1'b0;
        unique case (state)
            IDLE: begin
                if (ifWin || memWin) stateNext = ACCESS;
            end
            ACCESS: begin
                bus.ram_address = latAddr;
                bus.ram_data_in = latWdata;
                // latCnt still at its load value only in the first ACCESS cycle
                bus.ram_write_enable = latWe && (latCnt == LW'(RAM_LATENCY - 1));
                if (latCnt == '0) stateNext = RESP;
            end
            RESP: begin
                // A flush landing in the response cycle itself still kills the pulse.
                if (owner == OWN_IF) bus.if_rvalid = !(flushPend || bus.if_flush);
                else                 bus.mem_rvalid = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            owner     <= OWN_IF;
            latWe     <= 1'b0;
            latAddr   <= '0;
            latWdata  <= '0;
            latCnt    <= '0;
            flushPend <= 1'b0;
            ifRdata   <= '0;
            memRdata  <= '0;
        end else begin
            state <= stateNext;
            case (state)
                IDLE: begin
                    flushPend <= ifWin && bus.if_flush;
                    if (memWin) begin
                        owner    <= OWN_MEM;
                        latWe    <= bus.mem_we;
                        latAddr  <= bus.mem_addr;
                        latWdata <= bus.mem_wdata;
                        latCnt   <= LW'(RAM_LATENCY - 1);
                    end else if (ifWin) begin
                        owner    <= OWN_IF;
                        latWe    <= 1'b0;
                        latAddr  <= bus.if_addr;
                        latWdata <= '0;
                        latCnt   <= LW'(RAM_LATENCY - 1);
                    end
                end
                ACCESS: begin
                    if (owner == OWN_IF && bus.if_flush) flushPend <= 1'b1;
                    if (latCnt != '0)
                        latCnt <= latCnt - 1'b1;
                    else if (owner == OWN_IF)
                        ifRdata <= bus.ram_data_out;
                    else
                        memRdata <= latWe ? '0 : bus.ram_data_out;
                end
                RESP:    flushPend <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    localparam int L  = 1;
    localparam int MS = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tcyc = 0;
    int   nChk = 0;
    int   nFail = 0;
    int   ifRvCnt = 0, memRvCnt = 0, weCnt = 0;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LATENCY(L), .MAX_STREAK(MS)) dut (
        .clk(clk), .rst(rst), .bus(bus));
    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LATENCY(3), .MAX_STREAK(MS)) dut3 (
        .clk(clk), .rst(rst), .bus(bus3));

    initial forever #5 clk = ~clk;
    always @(posedge clk) tcyc <= tcyc + 1;

    function automatic logic [31:0] initVal(int i);
        return (i == 1) ? 32'h00A0_0093 : 32'hC0DE_0000 + 32'(i * 4);
    endfunction

    // RAM behind dut: combinational read, write on the clock edge.
    logic [31:0] ramMem [256];
    assign bus.ram_data_out = ramMem[bus.ram_address[9:2]];
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) ramMem[i] <= initVal(i);
        end else if (bus.ram_write_enable) begin
            ramMem[bus.ram_address[9:2]] <= bus.ram_data_in;
        end
    end
    assign bus3.ram_data_out = bus3.ram_address ^ 32'hA5A5_0000;

    always @(negedge clk) begin
        if (bus.if_rvalid)        ifRvCnt  <= ifRvCnt + 1;
        if (bus.mem_rvalid)       memRvCnt <= memRvCnt + 1;
        if (bus.ram_write_enable) weCnt    <= weCnt + 1;
    end

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChk++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        nChk++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %b, expected %b at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    int          cyc = 0, nextIdle = 0, streak = 0, tG = 0;
    bit          tValid = 0, tMem = 0, tWe = 0, tSup = 0;
    logic [31:0] tAddr = 0, tWdata = 0, tData = 0, expIfRdata = 0, expMemRdata = 0;
    logic [31:0] modelMem [256];

    task automatic modelStep();
        bit          idle, eIfG, eMemG, eWe, eIfRv, eMemRv;
        logic [31:0] eAddr, eDin;
        if (!rst) begin
            chk1("rst if_gnt", bus.if_gnt, 1'b0);
            chk1("rst mem_gnt", bus.mem_gnt, 1'b0);
            chk1("rst if_rvalid", bus.if_rvalid, 1'b0);
            chk1("rst mem_rvalid", bus.mem_rvalid, 1'b0);
            chk1("rst ram_we", bus.ram_write_enable, 1'b0);
            chk32("rst ram_address", bus.ram_address, 32'h0);
            chk32("rst ram_data_in", bus.ram_data_in, 32'h0);
            chk32("rst if_rdata", bus.if_rdata, 32'h0);
            chk32("rst mem_rdata", bus.mem_rdata, 32'h0);
            for (int i = 0; i < 256; i++) modelMem[i] = initVal(i);
            tValid = 0; streak = 0; nextIdle = 0;
            expIfRdata = 0; expMemRdata = 0;
        end else begin
            idle  = (cyc >= nextIdle);
            eIfG  = 0;
            eMemG = 0;
            if (idle) begin
                if (bus.mem_req && !(bus.if_req && streak == MS)) eMemG = 1;
                else if (bus.if_req) eIfG = 1;
            end
            eAddr = 0; eDin = 0; eWe = 0; eIfRv = 0; eMemRv = 0;
            if (tValid) begin
                if (cyc >= tG + 1 && cyc <= tG + L) begin
                    eAddr = tAddr;
                    eDin  = tWdata;
                    eWe   = tWe && (cyc == tG + 1);
                end
                if (!tMem && bus.if_flush) tSup = 1;
                if (cyc == tG + L + 1) begin
                    if (tMem) begin eMemRv = 1; expMemRdata = tData; end
                    else begin eIfRv = !tSup; expIfRdata = tData; end
                end
            end
            chk1("if_gnt", bus.if_gnt, eIfG);
            chk1("mem_gnt", bus.mem_gnt, eMemG);
            chk1("if_rvalid", bus.if_rvalid, eIfRv);
            chk1("mem_rvalid", bus.mem_rvalid, eMemRv);
            chk32("if_rdata", bus.if_rdata, expIfRdata);
            chk32("mem_rdata", bus.mem_rdata, expMemRdata);
            chk32("ram_address", bus.ram_address, eAddr);
            chk32("ram_data_in", bus.ram_data_in, eDin);
            chk1("ram_write_enable", bus.ram_write_enable, eWe);

            if (tValid && tWe && cyc == tG + 1) modelMem[tAddr[9:2]] = tWdata;
            if (tValid && cyc == tG + L + 1) tValid = 0;
            if (idle) begin
                if (!bus.if_req) streak = 0;
                if (eMemG) begin
                    if (bus.if_req) streak = (streak < MS) ? streak + 1 : MS;
                    tMem = 1; tWe = bus.mem_we; tAddr = bus.mem_addr; tWdata = bus.mem_wdata;
                    tData = bus.mem_we ? 32'h0 : modelMem[bus.mem_addr[9:2]];
                    tSup = 0;
                end else if (eIfG) begin
                    streak = 0;
                    tMem = 0; tWe = 0; tAddr = bus.if_addr; tWdata = 0;
                    tData = modelMem[bus.if_addr[9:2]];
                    tSup = bus.if_flush;
                end
                if (eMemG || eIfG) begin tValid = 1; tG = cyc; nextIdle = cyc + L + 2; end
            end
        end
        cyc++;
    endtask

    always @(negedge clk) modelStep();

    // ---------------- directed helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic waitGnt(input bit isMem, output int gc);
        bit got = 0;
        gc = -1;
        for (int i = 0; i < 40 && !got; i++) begin
            #2;
            if (isMem ? bus.mem_gnt : bus.if_gnt) begin got = 1; gc = tcyc; end
            tick();
            if (got) begin
                if (isMem) bus.mem_req = 1'b0;
                else       bus.if_req  = 1'b0;
            end
        end
        if (!got) begin
            nChk++; nFail++;
            $display("FAIL grant timeout: got none, expected grant (mem=%0d)", isMem);
        end
    endtask

    task automatic waitRv(input bit isMem, output int rc, output logic [31:0] d);
        bit got = 0;
        rc = -1;
        d  = '0;
        for (int i = 0; i < 20 && !got; i++) begin
            #2;
            if (isMem ? bus.mem_rvalid : bus.if_rvalid) begin
                got = 1; rc = tcyc;
                d = isMem ? bus.mem_rdata : bus.if_rdata;
            end
            tick();
        end
        if (!got) begin
            nChk++; nFail++;
            $display("FAIL rvalid timeout: got none, expected pulse (mem=%0d)", isMem);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          g, r, g2, c0, m0, w0, last, minGap, n, start;
        logic [31:0] d;
        string       seq;
        bit          ifG, mG;

        bus.if_req = 0; bus.if_addr = 0; bus.if_flush = 0;
        bus.mem_req = 0; bus.mem_we = 0; bus.mem_addr = 0; bus.mem_wdata = 0;
        bus3.if_req = 0; bus3.if_addr = 0; bus3.if_flush = 0;
        bus3.mem_req = 0; bus3.mem_we = 0; bus3.mem_addr = 0; bus3.mem_wdata = 0;
        repeat (3) @(posedge clk);
        #1;
        chk1("rst dut3 mem_rvalid", bus3.mem_rvalid, 1'b0);
        chk32("rst dut3 ram_address", bus3.ram_address, 32'h0);
        rst = 1'b1;
        tick();

        // 1: reset in the middle of a store
        bus.mem_req = 1; bus.mem_we = 1; bus.mem_addr = 32'h10; bus.mem_wdata = 32'hDEAD;
        waitGnt(1, g);
        bus.mem_we = 0;
        chk1("t1 we in access", bus.ram_write_enable, 1'b1);
        m0 = memRvCnt;
        #2 rst = 1'b0;
        #1;
        chk1("t1 we drops on reset", bus.ram_write_enable, 1'b0);
        chk32("t1 ram_address on reset", bus.ram_address, 32'h0);
        repeat (2) tick();
        rst = 1'b1;
        repeat (4) tick();
        chk32("t1 no mem_rvalid", 32'(memRvCnt - m0), 32'd0);

        // 2: lone fetch, granted immediately after reset release
        c0 = ifRvCnt; start = tcyc;
        bus.if_req = 1; bus.if_addr = 32'h04;
        waitGnt(0, g);
        chk32("t2 gnt immediate", 32'(g), 32'(start));
        waitRv(0, r, d);
        chk32("t2 latency", 32'(r - g), 32'd2);
        chk32("t2 if_rdata", d, 32'h00A0_0093);
        repeat (3) tick();
        chk32("t2 one pulse", 32'(ifRvCnt - c0), 32'd1);

        // 3: store then load
        w0 = weCnt;
        bus.mem_req = 1; bus.mem_we = 1; bus.mem_addr = 32'h20; bus.mem_wdata = 32'h1234_5678;
        waitGnt(1, g);
        bus.mem_we = 0;
        waitRv(1, r, d);
        chk32("t3 store rdata", d, 32'h0);
        chk32("t3 we cycles", 32'(weCnt - w0), 32'd1);
        bus.mem_req = 1; bus.mem_we = 0; bus.mem_addr = 32'h20; bus.mem_wdata = 32'h0;
        waitGnt(1, g);
        waitRv(1, r, d);
        chk32("t3 load rdata", d, 32'h1234_5678);

        // 4: contention with both requests held
        tick();
        bus.if_req = 1; bus.if_addr = 32'h0C;
        bus.mem_req = 1; bus.mem_we = 0; bus.mem_addr = 32'h40;
        seq = ""; last = -100; minGap = 1000; n = 0;
        for (int i = 0; i < 200 && n < 12; i++) begin
            #2;
            if (bus.mem_gnt || bus.if_gnt) begin
                seq = {seq, bus.mem_gnt ? "M" : "I"};
                if (tcyc - last < minGap) minGap = tcyc - last;
                last = tcyc;
                n++;
            end
            tick();
        end
        bus.if_req = 0; bus.mem_req = 0;
        nChk++;
        if (seq != "MMMMIMMMMIMM") begin
            nFail++;
            $display("FAIL t4 grant order: got %s, expected MMMMIMMMMIMM", seq);
        end
        chk32("t4 min gap", 32'(minGap), 32'(L + 2));
        repeat (4) tick();

        // 5: flushed fetch, concurrent load, then a normal fetch
        c0 = ifRvCnt;
        bus.if_req = 1; bus.if_addr = 32'h08;
        waitGnt(0, g);
        bus.if_flush = 1;
        bus.mem_req = 1; bus.mem_we = 0; bus.mem_addr = 32'h30; bus.mem_wdata = 32'h5555;
        tick();
        bus.if_flush = 0;
        waitGnt(1, g2);
        waitRv(1, r, d);
        chk32("t5 load rdata", d, 32'hC0DE_0030);
        repeat (2) tick();
        chk32("t5 flushed no rvalid", 32'(ifRvCnt - c0), 32'd0);
        bus.if_req = 1; bus.if_addr = 32'h40;
        waitGnt(0, g);
        waitRv(0, r, d);
        chk32("t5 next fetch rdata", d, 32'hC0DE_0040);
        chk32("t5 next fetch latency", 32'(r - g), 32'd2);

        // 6: latency-3 instance
        bus3.mem_req = 1; bus3.mem_we = 0; bus3.mem_addr = 32'h100;
        #2;
        chk1("t6 gnt", bus3.mem_gnt, 1'b1);
        tick();
        bus3.mem_req = 0;
        for (int k = 1; k <= 3; k++) begin
            #2;
            chk32("t6 ram_address", bus3.ram_address, 32'h100);
            chk1("t6 no early rvalid", bus3.mem_rvalid, 1'b0);
            tick();
        end
        #2;
        chk1("t6 rvalid at N+4", bus3.mem_rvalid, 1'b1);
        chk32("t6 rdata", bus3.mem_rdata, 32'hA5A5_0100);
        chk32("t6 ram_address idle", bus3.ram_address, 32'h0);
        tick();

        // random traffic, requesters hold until granted
        for (int c = 0; c < 1500; c++) begin
            #3;
            ifG = bus.if_gnt;
            mG  = bus.mem_gnt;
            tick();
            if (ifG) bus.if_req = 0;
            if (mG)  bus.mem_req = 0;
            if (!bus.if_req && $urandom_range(0, 2) == 0) begin
                bus.if_req  = 1;
                bus.if_addr = 32'($urandom_range(0, 255)) << 2;
            end
            if (!bus.mem_req && $urandom_range(0, 2) == 0) begin
                bus.mem_req   = 1;
                bus.mem_we    = 1'($urandom_range(0, 1));
                bus.mem_addr  = 32'($urandom_range(0, 255)) << 2;
                bus.mem_wdata = $urandom;
            end
            bus.if_flush = ($urandom_range(0, 9) == 0);
        end
        bus.if_req = 0; bus.mem_req = 0; bus.if_flush = 0;
        repeat (8) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
        $finish;
    end
endmodule
